// File: rtl/systolic_mac_array.sv
// ---------------------------------------------------------------------------
// systolic_mac_array
//
// Output-stationary M x P grid of multiply-accumulate PEs computing
// C = A*B (or C += A*B onto the retained accumulators).
// Row i of A enters the left edge delayed by i cycles, and column j of B
// enters the top edge delayed by j cycles. Each PE forwards its A operand
// to the right and its B operand downward through skew registers.
//
// Optional feature: define SYSTOLIC_SAT_EN to saturate each result element
// to the OUT_WIDTH range. Otherwise the low OUT_WIDTH bits are kept.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle request to begin a multiply
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   acc_en       1 = accumulate onto previous result, 0 = overwrite (sampled with start)
//   matrix_a     row-major A, element (i,k) at bit (i*N+k)*DATA_WIDTH
//   matrix_b     row-major B, element (k,j) at bit (k*P+j)*DATA_WIDTH
//   busy         high in LOAD, COMPUTE and DONE
//   done         one-cycle pulse; result_c is valid in the same cycle
//   result_c     row-major C, element (i,j) at bit (i*P+j)*OUT_WIDTH
//   state_dbg    current FSM state (IDLE=0, LOAD=1, COMPUTE=2, DONE=3)
//
// Handshake: start is accepted only while busy=0; a start seen while busy=1
// is dropped. Exactly one done pulse follows each accepted start, at a fixed
// M+N+P cycles after the accepting edge, unless reset intervenes.
// ---------------------------------------------------------------------------
module systolic_mac_array #(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 8,
  parameter int N          = 8,
  parameter int P          = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N) + 1,
  parameter int OUT_WIDTH  = DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           signed_mode,
  input  logic                           acc_en,
  input  logic [M*N*DATA_WIDTH-1:0]      matrix_a,
  input  logic [N*P*DATA_WIDTH-1:0]      matrix_b,
  output logic                           busy,
  output logic                           done,
  output logic [M*P*OUT_WIDTH-1:0]       result_c,
  output logic [1:0]                     state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // The last product reaches PE(M-1,P-1) at compute step (N-1)+(M-1)+(P-1).
  localparam int COMPUTE_CYCLES = M + N + P - 2;
  localparam int CNT_W          = $clog2(COMPUTE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COMPUTE_CYCLES - 1);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             sgn_q;
  logic             acc_en_q;

  logic [DATA_WIDTH-1:0] a_cap  [M][N];
  logic [DATA_WIDTH-1:0] b_cap  [N][P];
  logic [DATA_WIDTH-1:0] a_pipe [M][P];
  logic [DATA_WIDTH-1:0] b_pipe [M][P];
  logic [DATA_WIDTH-1:0] a_edge [M];
  logic [DATA_WIDTH-1:0] b_edge [P];
  logic [DATA_WIDTH-1:0] a_in   [M][P];
  logic [DATA_WIDTH-1:0] b_in   [M][P];
  logic [ACC_WIDTH-1:0]  acc_q  [M][P];
  logic [ACC_WIDTH-1:0]  prod   [M][P];

  function automatic logic [ACC_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] v,
                                               input logic sgn);
    if (sgn) ext = {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    else     ext = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, v};
  endfunction

`ifdef SYSTOLIC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] S_MAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] S_MIN = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] U_MAX = {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  // Clamp the full-precision accumulator into the result element range.
  function automatic logic [OUT_WIDTH-1:0] shape(input logic [ACC_WIDTH-1:0] v,
                                                 input logic sgn);
    if (sgn) begin
      if ($signed(v) > $signed(S_MAX))      shape = S_MAX[OUT_WIDTH-1:0];
      else if ($signed(v) < $signed(S_MIN)) shape = S_MIN[OUT_WIDTH-1:0];
      else                                  shape = v[OUT_WIDTH-1:0];
    end else begin
      if (v > U_MAX) shape = U_MAX[OUT_WIDTH-1:0];
      else           shape = v[OUT_WIDTH-1:0];
    end
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] shape(input logic [ACC_WIDTH-1:0] v);
    shape = v[OUT_WIDTH-1:0];
  endfunction
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = COMPUTE;
      COMPUTE: if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  // ---------------- Operand capture and step counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      acc_en_q <= 1'b0;
      for (int i = 0; i < M; i++)
        for (int k = 0; k < N; k++) a_cap[i][k] <= '0;
      for (int k = 0; k < N; k++)
        for (int j = 0; j < P; j++) b_cap[k][j] <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        sgn_q    <= signed_mode;
        acc_en_q <= acc_en;
      end
      if (state_q == LOAD) begin
        cnt_q <= '0;
        for (int i = 0; i < M; i++)
          for (int k = 0; k < N; k++)
            a_cap[i][k] <= matrix_a[(i*N+k)*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 0; k < N; k++)
          for (int j = 0; j < P; j++)
            b_cap[k][j] <= matrix_b[(k*P+j)*DATA_WIDTH +: DATA_WIDTH];
      end else if (state_q == COMPUTE) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // ---------------- Skewed edge feed ----------------
  // At step t, row i presents A(i, t-i) and column j presents B(t-j, j);
  // indices outside [0, N) inject zero.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_edge[i] = '0;
      for (int k = 0; k < N; k++)
        if (int'(cnt_q) == i + k) a_edge[i] = a_cap[i][k];
    end
    for (int j = 0; j < P; j++) begin
      b_edge[j] = '0;
      for (int k = 0; k < N; k++)
        if (int'(cnt_q) == j + k) b_edge[j] = b_cap[k][j];
    end
  end

  // PE operand routing: left column and top row take the edge feed, the rest
  // take the neighbour's skew register, so PE(i,j) sees index k = t-i-j.
  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_in[i][0] = a_edge[i];
      for (int j = 1; j < P; j++) a_in[i][j] = a_pipe[i][j-1];
    end
    for (int j = 0; j < P; j++) begin
      b_in[0][j] = b_edge[j];
      for (int i = 1; i < M; i++) b_in[i][j] = b_pipe[i-1][j];
    end
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++)
        prod[i][j] = ext(a_in[i][j], sgn_q) * ext(b_in[i][j], sgn_q);
  end

  // ---------------- PE grid ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++) begin
          acc_q[i][j]  <= '0;
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
        end
    end else if (state_q == LOAD) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++) begin
          if (!acc_en_q) acc_q[i][j] <= '0;
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
        end
    end else if (state_q == COMPUTE) begin
      // Sum wraps modulo 2^ACC_WIDTH by construction.
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++) begin
          acc_q[i][j]  <= acc_q[i][j] + prod[i][j];
          a_pipe[i][j] <= a_in[i][j];
          b_pipe[i][j] <= b_in[i][j];
        end
    end
  end

  // ---------------- Result register and done pulse ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      result_c <= '0;
    end else begin
      done <= (state_q == DONE);
      if (state_q == DONE) begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < P; j++)
`ifdef SYSTOLIC_SAT_EN
            result_c[(i*P+j)*OUT_WIDTH +: OUT_WIDTH] <= shape(acc_q[i][j], sgn_q);
`else
            result_c[(i*P+j)*OUT_WIDTH +: OUT_WIDTH] <= shape(acc_q[i][j]);
`endif
      end
    end
  end

endmodule

// File: doc/systolic_mac_array.md
SYSTOLIC_MAC_ARRAY -- requirements
Module: systolic_mac_array

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand element width, bits.
REQ-002 Parameter M, default 8: rows of A and C.
REQ-003 Parameter N, default 8: columns of A and rows of B (inner dimension).
REQ-004 Parameter P, default 8: columns of B and C.
REQ-005 Parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(N)+1: PE accumulator width.
REQ-006 Parameter OUT_WIDTH, default DATA_WIDTH: result element width.
REQ-007 clk  input  1  sole clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  single-cycle request to begin a multiply.
REQ-010 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-011 acc_en  input  1  1 = C += A*B onto the retained accumulators, 0 = C = A*B; sampled with start.
REQ-012 matrix_a  input  M*N*DATA_WIDTH  row-major A; element (i,k) at bit offset (i*N+k)*DATA_WIDTH.
REQ-013 matrix_b  input  N*P*DATA_WIDTH  row-major B; element (k,j) at bit offset (k*P+j)*DATA_WIDTH.
REQ-014 busy  output  1  high while an operation is in flight.
REQ-015 done  output  1  one-cycle pulse when result_c is valid.
REQ-016 result_c  output  M*P*OUT_WIDTH  row-major C; element (i,j) at bit offset (i*P+j)*OUT_WIDTH.

Function
REQ-017 The block SHALL be an output-stationary M x P grid of PEs, each performing one multiply-accumulate per cycle.
REQ-018 The FSM SHALL have states IDLE, LOAD, COMPUTE and DONE.
REQ-019 IDLE->LOAD on start=1; LOAD (1 cycle) captures matrix_a, matrix_b, signed_mode and acc_en into internal registers.
REQ-020 COMPUTE SHALL last exactly M+N+P-2 cycles; row i of A is skewed by i cycles and column j of B by j cycles, with zeros injected outside valid indices.
REQ-021 DONE (1 cycle) SHALL register result_c from the accumulators, pulse done=1, then return to IDLE.
REQ-022 Latency SHALL be fixed: done asserts M+N+P cycles after the edge that sampled start.
REQ-023 busy SHALL be 1 in LOAD, COMPUTE and DONE, and 0 in IDLE.
REQ-024 start while busy=1 SHALL be ignored with no effect on the operation in flight or on result_c.
REQ-025 Operands SHALL be sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to ACC_WIDTH before the multiply.
REQ-026 When acc_en=0, accumulators SHALL clear to 0 in LOAD; when acc_en=1, they SHALL retain full-precision values from the previous operation.
REQ-027 Accumulator overflow beyond ACC_WIDTH SHALL wrap modulo 2^ACC_WIDTH.
REQ-028 Matrix inputs SHALL be sampled only in LOAD; changes at any other time SHALL have no effect.
REQ-029 result_c SHALL hold its value from DONE until the next DONE or reset.

Reset
REQ-030 rst_n=0 SHALL immediately force the FSM to IDLE and set busy=0, done=0, result_c=0, all accumulators and skew registers to 0, regardless of state.
REQ-031 An operation aborted by reset SHALL NOT produce a done pulse; start is honoured from the first edge after rst_n=1.

Configuration
REQ-032 With SYSTOLIC_SAT_EN defined, each result element SHALL saturate to the OUT_WIDTH range: signed [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] or unsigned [0, 2^OUT_WIDTH-1], per the captured signed_mode.
REQ-033 Without SYSTOLIC_SAT_EN, each result element SHALL be the low OUT_WIDTH bits of the accumulator (truncation).

Verification
REQ-034 Defaults; A=identity, B(k,j)=k*8+j-32, signed -> result_c equals B in the low 8 bits of each element; done exactly 24 cycles after start.
REQ-035 All A=B=-128, signed, N=8; sum=131072 -> SAT_EN: every element 127 (0x7F); no SAT_EN: every element 0x00.
REQ-036 All A=B=255, unsigned -> SAT_EN: every element 255; no SAT_EN: every element low 8 bits of 520200 (0x08).
REQ-037 A=B=all 1s, run acc_en=0, then acc_en=1 -> first result 8 per element, second result 16 per element.
REQ-038 Second start pulse 5 cycles after the first -> ignored; a single done pulse at 24 cycles with the first result.
REQ-039 rst_n=0 for 1 cycle mid-COMPUTE -> busy=0 and result_c=0 immediately; no done pulse; a fresh start then completes correctly.
